apb_gpio_infilter: RTL
======================

// Module: apb_gpio_infilter
// PURPOSE
//  Input-conditioning stage directly upstream of apb_gpio: takes raw asynchronous pad inputs,
//  synchronises them to PCLK, applies a per-bit programmable glitch filter (stable-for-N-cycles)
//  and drives the clean vector into apb_gpio.gpio_i. Also emits one-cycle rise/fall pulses per bit
//  for edge-triggered IRQ logic. No bus interface; configuration comes from register outputs.
// PARAMETERS
//  PDATA_SIZE   8  number of GPIO bits (matches apb_gpio PDATA_SIZE)
//  SYNC_STAGES  2  synchroniser flops per bit; legal range 2..4
//  CNT_WIDTH    8  width of filter length / per-bit counter
// PORTS
//  PCLK      in   1           system clock, all logic on rising edge
//  PRESET    in   1           asynchronous, active-high reset
//  pad_i     in   PDATA_SIZE  raw asynchronous pad inputs
//  filt_en   in   PDATA_SIZE  per-bit filter enable; 0 = bypass (sync only)
//  filt_len  in   CNT_WIDTH   required stable cycles N, shared by all bits; 0 treated as 1
//  gpio_i    out  PDATA_SIZE  filtered input, registered; connects to apb_gpio gpio_i
//  rise_o    out  PDATA_SIZE  1-cycle pulse when gpio_i[b] goes 0->1
//  fall_o    out  PDATA_SIZE  1-cycle pulse when gpio_i[b] goes 1->0
//  change_o  out  1           OR of all rise_o|fall_o bits, registered alongside them
// BEHAVIOUR
//  - Reset (PRESET=1, async): sync chain, counters, gpio_i, rise_o, fall_o, change_o all 0.
//    Release of reset generates no edge pulses.
//  - Sync: pad_i[b] shifts through SYNC_STAGES flops -> s[b]; no reset-value pulses exported.
//  - Bypass (filt_en[b]=0): gpio_i[b] <= s[b] each edge; counter[b] held 0.
//    Latency pad->gpio_i = SYNC_STAGES+1 edges.
//  - Filtered (filt_en[b]=1), Neff = max(filt_len,1):
//    * s[b]==gpio_i[b]: counter[b] <= 0.
//    * s[b]!=gpio_i[b] and counter[b] >= Neff-1: gpio_i[b] <= s[b], counter[b] <= 0.
//    * s[b]!=gpio_i[b] otherwise: counter[b] <= counter[b]+1.
//    Latency pad->gpio_i = SYNC_STAGES+Neff edges; any glitch shorter than Neff synced cycles
//    leaves gpio_i unchanged and is fully forgotten (counter restarts from 0).
//  - filt_len lowered mid-count: compare is >=, so update on next mismatching cycle; never wraps.
//    filt_len raised mid-count: counting continues to new Neff-1. Counter never exceeds 2^CNT_WIDTH-1.
//  - filt_en 1->0 mid-count: counter cleared, gpio_i[b] takes s[b] next edge (pulse if it differs).
//    filt_en 0->1: filtering starts from counter 0 against current gpio_i[b].
//  - Edges: rise_o[b]/fall_o[b] are registered on the same edge gpio_i[b] updates, i.e. high
//    exactly in the first cycle gpio_i[b] shows its new value; high for one cycle only.
//    change_o is the OR of all rise|fall bits, same cycle. Bits are fully independent;
//    simultaneous edges on several bits all pulse in the same cycle.
//  - Reset asserted mid-filter: everything clears immediately; after release, a pad held at 1
//    yields a normal rise after full latency.
// STRUCTURE
//  - Package apb_gpio_pkg: SYNC_STAGES_DEF, CNT_WIDTH_DEF constants; typedef edge_t {rise,fall}.
//  - Sub-module apb_gpio_infilter_bit: sync chain + counter + output/edge flops for one bit;
//    top instantiates PDATA_SIZE copies via generate and ORs edges into change_o.
// TESTING
//  1 Reset: PRESET=1 with pad_i=8'hFF -> gpio_i=0, rise_o=fall_o=0, change_o=0; release -> no pulse
//    until rise_o=8'hFF exactly SYNC_STAGES+Neff edges later.
//  2 Bypass: filt_en=0, pad_i 8'h00->8'h5A -> gpio_i=8'h5A after 3 edges (SYNC_STAGES=2),
//    rise_o=8'h5A for one cycle, change_o=1 same cycle.
//  3 Glitch reject: filt_en=8'h01, filt_len=4, pad_i[0] high for 3 cycles -> gpio_i[0] stays 0,
//    no pulse; high for 4 cycles -> gpio_i[0]=1 at edge 2+4, rise_o[0] single pulse.
//  4 filt_len=0: behaves as 1 -> pad change visible after SYNC_STAGES+1 edges, like bypass.
//  5 Config change mid-count: filt_len=10, mismatch held 6 cycles, then filt_len=3 -> gpio_i
//    updates on next edge; filt_en cleared mid-count -> gpio_i follows s next edge.
//  6 Reset mid-operation: assert PRESET during count 5 of 8 -> outputs 0 immediately; release with
//    pad high -> fresh rise after full 2+8 edges, no spurious fall_o.

Source files
------------

// File: rtl/apb_gpio_pkg.sv
// Shared constants and types for the GPIO input-conditioning path.
package apb_gpio_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_WIDTH_DEF   = 8;

    // Edge pair for a single GPIO bit.
    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

    // Classify the transition between the current and next filtered value.
    function automatic edge_t edge_detect(input logic cur, input logic nxt);
        edge_t e;
        e.rise = nxt & ~cur;
        e.fall = ~nxt & cur;
        return e;
    endfunction

endpackage

// File: rtl/apb_gpio_infilter_bit.sv
// One GPIO bit: synchroniser chain, stable-for-N glitch filter and edge flops.
// The filter counts consecutive synced samples that disagree with the current
// output; the output only follows once the count reaches the threshold.
// The threshold comparison is ">=" so lowering it mid-count cannot strand a
// counter above the new limit, and the counter never wraps.
module apb_gpio_infilter_bit
    import apb_gpio_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 pad,
    input  logic                 filt_en,
    input  logic [CNT_WIDTH-1:0] thresh,     // Neff-1, already clamped by the top
    output logic                 gpio,
    output logic                 rise,
    output logic                 fall,
    output logic                 edge_any    // next-cycle rise|fall, for change_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic [CNT_WIDTH-1:0]   cnt_nxt_s;
    logic                   gpio_r;
    logic                   gpio_nxt_s;
    logic                   sync_s;
    edge_t                  edge_r;
    edge_t                  edge_nxt_s;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Filter decision: bypass, agree, accept after threshold, or keep counting.
    always_comb begin
        gpio_nxt_s = gpio_r;
        cnt_nxt_s  = cnt_r;
        if (!filt_en) begin
            gpio_nxt_s = sync_s;
            cnt_nxt_s  = '0;
        end else if (sync_s == gpio_r) begin
            cnt_nxt_s  = '0;
        end else if (cnt_r >= thresh) begin
            gpio_nxt_s = sync_s;
            cnt_nxt_s  = '0;
        end else begin
            cnt_nxt_s  = cnt_r + CNT_ONE;
        end
        edge_nxt_s = edge_detect(gpio_r, gpio_nxt_s);
    end

    // Synchroniser, counter, filtered value and edge pulses share one clock edge.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync_r <= '0;
            cnt_r  <= '0;
            gpio_r <= 1'b0;
            edge_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pad};
            cnt_r  <= cnt_nxt_s;
            gpio_r <= gpio_nxt_s;
            edge_r <= edge_nxt_s;
        end
    end

    assign gpio     = gpio_r;
    assign rise     = edge_r.rise;
    assign fall     = edge_r.fall;
    assign edge_any = edge_nxt_s.rise | edge_nxt_s.fall;

endmodule

// File: rtl/apb_gpio_infilter.sv
// Input conditioning in front of apb_gpio: per-bit sync + glitch filter,
// with registered rise/fall pulses and a combined change flag.
// SYNC_STAGES must lie in 2..4.
module apb_gpio_infilter
    import apb_gpio_pkg::*;
#(
    parameter int PDATA_SIZE  = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [PDATA_SIZE-1:0] pad_i,
    input  logic [PDATA_SIZE-1:0] filt_en,
    input  logic [CNT_WIDTH-1:0]  filt_len,
    output logic [PDATA_SIZE-1:0] gpio_i,
    output logic [PDATA_SIZE-1:0] rise_o,
    output logic [PDATA_SIZE-1:0] fall_o,
    output logic                  change_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0]  thresh_s;
    logic [PDATA_SIZE-1:0] edge_any_s;
    logic                  change_r;

    // Shared threshold Neff-1, with a length of 0 behaving like 1.
    always_comb begin
        if (filt_len == '0) begin
            thresh_s = '0;
        end else begin
            thresh_s = filt_len - CNT_ONE;
        end
    end

    for (genvar b = 0; b < PDATA_SIZE; b++) begin : g_bit
        apb_gpio_infilter_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_WIDTH   (CNT_WIDTH)
        ) u_bit (
            .PCLK     (PCLK),
            .PRESET   (PRESET),
            .pad      (pad_i[b]),
            .filt_en  (filt_en[b]),
            .thresh   (thresh_s),
            .gpio     (gpio_i[b]),
            .rise     (rise_o[b]),
            .fall     (fall_o[b]),
            .edge_any (edge_any_s[b])
        );
    end

    // change_o registered on the same edge as the per-bit pulses.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            change_r <= 1'b0;
        end else begin
            change_r <= |edge_any_s;
        end
    end

    assign change_o = change_r;

endmodule
